// File: rtl/useq_pkg.sv
// Shared definitions for the micro-sequencer: next-address encodings,
// control-word field positions and condition bit indices.
package useq_pkg;

  typedef enum logic [2:0] {
    NEXT_INC  = 3'b000,
    NEXT_JMP  = 3'b001,
    NEXT_DISP = 3'b010,
    NEXT_CBR  = 3'b011,
    NEXT_2WAY = 3'b100,
    NEXT_WAIT = 3'b101,
    NEXT_CALL = 3'b110,
    NEXT_RET  = 3'b111
  } next_e;

  localparam int N_LSB   = 55;
  localparam int INV_BIT = 54;
  localparam int S_LSB   = 50;
  localparam int CRB_LSB = 42;
  localparam int CRA_LSB = 34;
  localparam int CTRL_W  = 34;

  localparam int MOC       = 0;
  localparam int COND_PASS = 1;

  typedef struct packed {
    next_e             n;
    logic              inv;
    logic [2:0]        s;
    logic [7:0]        crb;
    logic [7:0]        cra;
    logic [CTRL_W-1:0] ctrl;
  } uword_t;

  function automatic uword_t decode(input logic [63:0] w);
    uword_t u;
    u.n    = next_e'(w[N_LSB +: 3]);
    u.inv  = w[INV_BIT];
    u.s    = w[S_LSB +: 3];
    u.crb  = w[CRB_LSB +: 8];
    u.cra  = w[CRA_LSB +: 8];
    u.ctrl = w[CTRL_W-1:0];
    return u;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Return-address stack for microcode call/return.
// Overflowing pushes are dropped, empty pops leave sp alone; both set err.
module useq_stack
  import useq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] push_data,
  output logic [7:0] top_data,
  output logic       empty,
  output logic       err
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] sp_q, sp_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          err_q, err_d;
  logic          full;
  logic [AW-1:0] wr_idx, rd_idx;

  always_comb begin
    full   = (sp_q == PW'(DEPTH));
    empty  = (sp_q == '0);
    wr_idx = AW'(sp_q);
    rd_idx = AW'(sp_q - PW'(1));
    sp_d   = sp_q;
    mem_d  = mem_q;
    err_d  = err_q;
    if (push) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        mem_d[wr_idx] = push_data;
        sp_d          = sp_q + PW'(1);
      end
    end else if (pop) begin
      if (empty) err_d = 1'b1;
      else       sp_d  = sp_q - PW'(1);
    end
  end

  assign top_data = mem_q[rd_idx];
  assign err      = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: combinational next-address select, registered ctrl.
// Define USEQ_SUBROUTINE_EN to add call/return through useq_stack.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter logic [7:0] RESET_ADDR  = 8'd0,
  parameter int         STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [7:0]        rom_addr,
  input  logic [63:0]       rom_word,
  input  logic [7:0]        dispatch_addr,
  input  logic [7:0]        cond,
  input  logic              stall,
  output logic [CTRL_W-1:0] ctrl,
  output logic              ctrl_valid,
  output logic              stack_err
);

  logic [7:0]        rom_addr_q, rom_addr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic [7:0]        next_addr, inc;
  logic              c;
  uword_t            w;

  wire unused_bits  = ^{rom_word[63:58], rom_word[53]};
  wire unused_depth = (STACK_DEPTH > 0);

`ifdef USEQ_SUBROUTINE_EN
  logic       push, pop, stk_empty, stk_err;
  logic [7:0] stk_top;

  useq_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .push_data(inc),
    .top_data (stk_top),
    .empty    (stk_empty),
    .err      (stk_err)
  );

  assign stack_err = stk_err;
`else
  assign stack_err = 1'b0;
`endif

  always_comb begin
    w         = decode(rom_word);
    inc       = rom_addr_q + 8'd1;
    c         = cond[w.s] ^ w.inv;
    next_addr = RESET_ADDR;
`ifdef USEQ_SUBROUTINE_EN
    push      = 1'b0;
    pop       = 1'b0;
`endif
    unique case (w.n)
      NEXT_INC:  next_addr = inc;
      NEXT_JMP:  next_addr = w.cra;
      NEXT_DISP: next_addr = dispatch_addr;
      NEXT_CBR:  next_addr = c ? w.cra : inc;
      NEXT_2WAY: next_addr = c ? w.cra : w.crb;
      NEXT_WAIT: next_addr = c ? inc : rom_addr_q;
`ifdef USEQ_SUBROUTINE_EN
      NEXT_CALL: begin
        push      = !stall;
        next_addr = w.cra;
      end
      NEXT_RET: begin
        pop       = !stall;
        next_addr = stk_empty ? RESET_ADDR : stk_top;
      end
`else
      NEXT_CALL: next_addr = RESET_ADDR;
      NEXT_RET:  next_addr = RESET_ADDR;
`endif
    endcase
  end

  always_comb begin
    rom_addr_d   = stall ? rom_addr_q : next_addr;
    ctrl_d       = stall ? ctrl_q : w.ctrl;
    ctrl_valid_d = stall ? ctrl_valid_q : 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q   <= RESET_ADDR;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
    end else begin
      rom_addr_q   <= rom_addr_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign ctrl       = ctrl_q;
  assign ctrl_valid = ctrl_valid_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer driving a bench-owned control ROM.
// Build with USEQ_SUBROUTINE_EN defined to exercise the return stack.
module tb_micro_sequencer;
  import useq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rom_addr;
  logic [63:0] rom_word;
  logic [7:0]  dispatch_addr;
  logic [7:0]  cond;
  logic        stall;
  logic [33:0] ctrl;
  logic        ctrl_valid;
  logic        stack_err;

  logic [63:0] rom [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_word = rom[rom_addr];

  micro_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rom_addr     (rom_addr),
    .rom_word     (rom_word),
    .dispatch_addr(dispatch_addr),
    .cond         (cond),
    .stall        (stall),
    .ctrl         (ctrl),
    .ctrl_valid   (ctrl_valid),
    .stack_err    (stack_err)
  );

  function automatic logic [33:0] cw(input logic [7:0] a);
    return {a[1:0], ~a, a, ~a, a};
  endfunction

  // Junk in [63:58] and [53] must not influence sequencing.
  function automatic logic [63:0] mk(input logic [2:0] n, input logic inv,
                                     input logic [2:0] s,
                                     input logic [7:0] crb,
                                     input logic [7:0] cra,
                                     input logic [7:0] a);
    return {6'h2A, n, inv, 1'b1, s, crb, cra, cw(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [7:0] a,
                    input logic [7:0] ca);
    chk({tag, "_addr"}, rom_addr, a);
    chk({tag, "_ctrl"}, ctrl, cw(ca));
  endtask

  task automatic rst_state(input string tag);
    chk({tag, "_addr"}, rom_addr, 8'd0);
    chk({tag, "_ctrl"}, ctrl, 34'd0);
    chk({tag, "_valid"}, ctrl_valid, 1'b0);
    chk({tag, "_err"}, stack_err, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = mk(NEXT_INC, 1'b0, 3'd0, 8'd0, 8'd0, 8'(i));
    rom[0]   = mk(NEXT_2WAY, 1'b0, 3'd2, 8'd7,  8'd5,  8'd0);
    rom[1]   = mk(NEXT_CBR,  1'b0, 3'd1, 8'd0,  8'd40, 8'd1);
    rom[2]   = mk(NEXT_CBR,  1'b1, 3'd1, 8'd0,  8'd40, 8'd2);
    rom[3]   = mk(NEXT_WAIT, 1'b0, 3'd0, 8'd0,  8'd0,  8'd3);
    rom[4]   = mk(NEXT_2WAY, 1'b0, 3'd1, 8'd30, 8'd50, 8'd4);
    rom[6]   = mk(NEXT_JMP,  1'b0, 3'd0, 8'd0,  8'd255, 8'd6);
    rom[7]   = mk(NEXT_CBR,  1'b0, 3'd3, 8'd0,  8'd60, 8'd7);
    rom[8]   = mk(NEXT_JMP,  1'b0, 3'd0, 8'd0,  8'd1,  8'd8);
`ifdef USEQ_SUBROUTINE_EN
    rom[10]  = mk(NEXT_CALL, 1'b0, 3'd0, 8'd0,  8'd44, 8'd10);
`else
    rom[10]  = mk(NEXT_RET,  1'b0, 3'd0, 8'd0,  8'd0,  8'd10);
`endif
    rom[11]  = mk(NEXT_RET,  1'b0, 3'd0, 8'd0,  8'd0,  8'd11);
    rom[17]  = mk(NEXT_JMP,  1'b0, 3'd0, 8'd0,  8'd10, 8'd17);
    rom[30]  = mk(NEXT_DISP, 1'b0, 3'd0, 8'd0,  8'd0,  8'd30);
    rom[40]  = mk(NEXT_JMP,  1'b0, 3'd0, 8'd0,  8'd2,  8'd40);
    rom[44]  = mk(NEXT_RET,  1'b0, 3'd0, 8'd0,  8'd0,  8'd44);
    for (int i = 60; i < 65; i++)
      rom[i] = mk(NEXT_CALL, 1'b0, 3'd0, 8'd0, 8'(i + 1), 8'(i));
    rom[65]  = mk(NEXT_RET,  1'b0, 3'd0, 8'd0,  8'd0,  8'd65);

    reset_n       = 1'b0;
    stall         = 1'b0;
    dispatch_addr = 8'd0;
    cond          = 8'b0000_0100;
    repeat (2) tick();
    rst_state("reset");
    reset_n = 1'b1;

    tick(); st("first", 8'd5, 8'd0);
    chk("first_valid", ctrl_valid, 1'b1);
    tick(); st("inc", 8'd6, 8'd5);
    tick(); st("jmp", 8'd255, 8'd6);
    cond = 8'b0000_0000;
    tick(); st("wrap", 8'd0, 8'd255);
    tick(); st("crb0", 8'd7, 8'd0);
    tick(); st("cbr_nt", 8'd8, 8'd7);
    tick(); st("jmp1", 8'd1, 8'd8);
    cond = 8'b0000_0010;
    tick(); st("cbr_t", 8'd40, 8'd1);
    tick(); st("jmp2", 8'd2, 8'd40);
    tick(); st("cbr_inv", 8'd3, 8'd2);
    for (int i = 0; i < 3; i++) begin
      tick(); st("wait", 8'd3, 8'd3);
    end
    cond = 8'b0000_0011;
    tick(); st("wait_exit", 8'd4, 8'd3);
    cond = 8'b0000_0001;
    tick(); st("2way_crb", 8'd30, 8'd4);
    dispatch_addr = 8'd16;
    tick(); st("disp", 8'd16, 8'd30);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); st("stall", 8'd16, 8'd30);
      chk("stall_valid", ctrl_valid, 1'b1);
    end
    stall = 1'b0;
    tick(); st("unstall", 8'd17, 8'd16);
    tick(); st("to10", 8'd10, 8'd17);

`ifdef USEQ_SUBROUTINE_EN
    tick(); st("call", 8'd44, 8'd10);
    chk("call_err", stack_err, 1'b0);
    tick(); st("ret", 8'd11, 8'd44);
    tick(); st("ret_empty", 8'd0, 8'd11);
    chk("ret_empty_err", stack_err, 1'b1);
    cond = 8'b0000_1000;
    tick(); st("sticky", 8'd7, 8'd0);
    chk("sticky_err", stack_err, 1'b1);
    reset_n = 1'b0;
    #1;
    rst_state("err_clr");
    reset_n = 1'b1;
    tick(); st("re0", 8'd7, 8'd0);
    tick(); st("re1", 8'd60, 8'd7);
    for (int k = 0; k < 4; k++) begin
      tick(); st("nest", 8'(61 + k), 8'(60 + k));
      chk("nest_err", stack_err, 1'b0);
    end
    tick(); st("overflow", 8'd65, 8'd64);
    chk("overflow_err", stack_err, 1'b1);
`else
    tick(); st("ret_off", 8'd0, 8'd10);
    chk("ret_off_err", stack_err, 1'b0);
    cond = 8'b0000_1000;
    tick(); st("off0", 8'd7, 8'd0);
    tick(); st("off1", 8'd60, 8'd7);
    tick(); st("call_off", 8'd0, 8'd60);
    chk("call_off_err", stack_err, 1'b0);
`endif

    cond    = 8'b0000_0010;
    reset_n = 1'b0;
    #1;
    rst_state("pulse");
    reset_n = 1'b1;
    tick(); st("p0", 8'd7, 8'd0);
    tick(); st("p1", 8'd8, 8'd7);
    tick(); st("p2", 8'd1, 8'd8);
    tick(); st("p3", 8'd40, 8'd1);
    tick(); st("p4", 8'd2, 8'd40);
    tick(); st("p5", 8'd3, 8'd2);
    tick(); st("p_wait", 8'd3, 8'd3);
    #2;
    reset_n = 1'b0;
    #1;
    rst_state("mid_wait");
    stall = 1'b1;
    tick();
    rst_state("rst_stall");
    reset_n = 1'b1;
    stall   = 1'b0;
    tick(); st("after_wait_rst", 8'd7, 8'd0);
    chk("after_wait_valid", ctrl_valid, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
